// File: rtl/alu_4bit_if.sv
// Operand, opcode and flag bundle between the CPU control path and the ALU.
// The master drives operands and opcode. The slave (the ALU) returns the result and flags.
interface alu_4bit_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       opcode;
    logic             flag_en;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             negative;
    logic [3:0]       flags_q;

    modport master (
        output a,
        output b,
        output opcode,
        output flag_en,
        input  result,
        input  zero,
        input  carry,
        input  overflow,
        input  negative,
        input  flags_q
    );

    modport slave (
        input  a,
        input  b,
        input  opcode,
        input  flag_en,
        output result,
        output zero,
        output carry,
        output overflow,
        output negative,
        output flags_q
    );
endinterface

// File: rtl/alu_4bit.sv
// Combinational 8-operation ALU with zero/carry/overflow/negative flags,
// plus a flag register that captures {negative, overflow, carry, zero} when enabled.
module alu_4bit #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_4bit_if.slave  bus
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   sumExt;
    logic [WIDTH:0]   diffExt;
    logic [WIDTH-1:0] resultC;
    logic             carryC;
    logic             overflowC;
    logic             zeroC;
    logic             negativeC;
    logic [3:0]       flags_d;
    logic [3:0]       flags_reg_q;

    // Bit WIDTH of the extended difference is set exactly when a < b, so it is used as the borrow.
    assign sumExt  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diffExt = {1'b0, bus.a} - {1'b0, bus.b};

    always_comb begin
        resultC   = '0;
        carryC    = 1'b0;
        overflowC = 1'b0;
        case (bus.opcode)
            OP_AND: resultC = bus.a & bus.b;
            OP_OR:  resultC = bus.a | bus.b;
            OP_ADD: begin
                resultC   = sumExt[WIDTH-1:0];
                carryC    = sumExt[WIDTH];
                overflowC = (bus.a[MSB] == bus.b[MSB]) && (sumExt[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                resultC   = diffExt[WIDTH-1:0];
                carryC    = diffExt[WIDTH];
                overflowC = (bus.a[MSB] != bus.b[MSB]) && (diffExt[MSB] != bus.a[MSB]);
            end
            OP_NOT: resultC = ~bus.a;
            OP_XOR: resultC = bus.a ^ bus.b;
            OP_SHL: begin
                resultC = {bus.a[WIDTH-2:0], 1'b0};
                carryC  = bus.a[MSB];
            end
            OP_SHR: begin
                resultC = {1'b0, bus.a[WIDTH-1:1]};
                carryC  = bus.a[0];
            end
            default: begin
                resultC   = '0;
                carryC    = 1'b0;
                overflowC = 1'b0;
            end
        endcase
    end

    assign zeroC     = (resultC == '0);
    assign negativeC = resultC[MSB];

    assign bus.result   = resultC;
    assign bus.zero     = zeroC;
    assign bus.carry    = carryC;
    assign bus.overflow = overflowC;
    assign bus.negative = negativeC;

    assign flags_d = bus.flag_en ? {negativeC, overflowC, carryC, zeroC} : flags_reg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_reg_q <= 4'b0000;
        end else begin
            flags_reg_q <= flags_d;
        end
    end

    assign bus.flags_q = flags_reg_q;

endmodule

// File: tb/tb_alu_4bit.sv
// Directed-vector bench for alu_4bit: combinational ops and flags, then the flag
// register's enable, hold and asynchronous clear behaviour.
module tb_alu_4bit;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   errorCount;

    alu_4bit_if #(.WIDTH(4)) bus ();

    alu_4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison in the bench goes through here so the counts stay consistent.
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] aVal, input logic [3:0] bVal,
                                 input logic [2:0] opVal, input logic enVal);
        bus.a       = aVal;
        bus.b       = bVal;
        bus.opcode  = opVal;
        bus.flag_en = enVal;
        #1;
    endtask

    task automatic runVector(input string tag, input logic [3:0] aVal, input logic [3:0] bVal,
                             input logic [2:0] opVal, input logic [3:0] expResult,
                             input logic expZ, input logic expC, input logic expV, input logic expN);
        applyStimulus(aVal, bVal, opVal, 1'b0);
        checkOutput({tag, ".result"},   {4'b0, bus.result},   {4'b0, expResult});
        checkOutput({tag, ".zero"},     {7'b0, bus.zero},     {7'b0, expZ});
        checkOutput({tag, ".carry"},    {7'b0, bus.carry},    {7'b0, expC});
        checkOutput({tag, ".overflow"}, {7'b0, bus.overflow}, {7'b0, expV});
        checkOutput({tag, ".negative"}, {7'b0, bus.negative}, {7'b0, expN});
    endtask

    task automatic checkFlags(input string tag, input logic [3:0] expFlags);
        checkOutput(tag, {4'b0, bus.flags_q}, {4'b0, expFlags});
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst_n      = 1'b0;
        applyStimulus(4'h0, 4'h0, 3'b000, 1'b0);
        #2;
        checkFlags("resetFlags", 4'b0000);

        // Combinational paths must work even while the flag register is held in reset.
        runVector("andInReset", 4'b1100, 4'b1010, 3'b000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1);

        @(negedge clk);
        rst_n = 1'b1;

        runVector("and",     4'b1100, 4'b1010, 3'b000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1);
        runVector("or",      4'b1100, 4'b1010, 3'b001, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b1);
        runVector("add3p5",  4'b0011, 4'b0101, 3'b010, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1);
        runVector("addWrap", 4'b1111, 4'b0001, 3'b010, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        runVector("add7p1",  4'b0111, 4'b0001, 3'b010, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1);
        runVector("sub8m8",  4'b1000, 4'b1000, 3'b011, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        runVector("subWrap", 4'b0000, 4'b0001, 3'b011, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1);
        runVector("sub8m1",  4'b1000, 4'b0001, 3'b011, 4'b0111, 1'b0, 1'b0, 1'b1, 1'b0);
        runVector("sub5m3",  4'b0101, 4'b0011, 3'b011, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
        runVector("not",     4'b1100, 4'b0000, 3'b100, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
        runVector("notBIgn", 4'b0101, 4'b1111, 3'b100, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1);
        runVector("xorSame", 4'b1010, 4'b1010, 3'b101, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        runVector("xor",     4'b1010, 4'b0110, 3'b101, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b1);
        runVector("shl",     4'b1001, 4'b1111, 3'b110, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0);
        runVector("shlNeg",  4'b0111, 4'b0000, 3'b110, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b1);
        runVector("shr",     4'b1001, 4'b1111, 3'b111, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0);
        runVector("shrZero", 4'b0001, 4'b0000, 3'b111, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);

        checkFlags("holdAfterComb", 4'b0000);

        // Load a nonzero value so the asynchronous clear can be observed.
        @(negedge clk);
        applyStimulus(4'b0011, 4'b0101, 3'b010, 1'b1);
        @(posedge clk);
        #1;
        checkFlags("preload", 4'b1100);

        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkFlags("asyncClear", 4'b0000);
        @(posedge clk);
        #1;
        checkFlags("heldInReset", 4'b0000);

        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b1000, 4'b1000, 3'b011, 1'b1);
        @(posedge clk);
        #1;
        checkFlags("captureSub", 4'b0001);

        @(negedge clk);
        applyStimulus(4'b0011, 4'b0101, 3'b010, 1'b0);
        @(posedge clk);
        #1;
        checkFlags("holdDisabled", 4'b0001);

        @(negedge clk);
        applyStimulus(4'b0011, 4'b0101, 3'b010, 1'b1);
        @(posedge clk);
        #1;
        checkFlags("captureAdd", 4'b1100);

        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkFlags("midCycleClear", 4'b0000);
        #1;
        rst_n = 1'b1;
        #1;
        checkFlags("clearPersists", 4'b0000);
        @(posedge clk);
        #1;
        checkFlags("reloadAfterReset", 4'b1100);

        @(negedge clk);
        applyStimulus(4'b1111, 4'b0001, 3'b010, 1'b1);
        @(posedge clk);
        #1;
        checkFlags("captureWrap", 4'b0011);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
